// File: rtl/als_adc_responder_if.sv
// ---------------------------------------------------------------------------
// als_adc_responder_if
// Serial link between the light-sensor ADC initiator and its target.
//   CS  : chip select, active-low, driven by the initiator
//   SCK : serial clock, driven by the initiator
//   SDO : serial data, driven by the target
// Modports:
//   master : initiator side (drives CS/SCK, reads SDO)
//   slave  : target side    (reads CS/SCK, drives SDO)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface als_adc_responder_if;
    logic CS;
    logic SCK;
    logic SDO;

    modport master (output CS, output SCK, input SDO);
    modport slave  (input CS, input SCK, output SDO);
endinterface

// File: rtl/als_adc_responder.sv
// ---------------------------------------------------------------------------
// als_adc_responder
// Target-side emulation of the 8-bit serial light-sensor ADC. CS and SCK are
// oversampled on the 25 MHz pixel clock; a held sample is shifted out on SDO
// as LEAD_Z zero bits, the sample MSB first, then zero padding to FRAME_LEN.
// Ports:
//   clk_25M      : system clock
//   reset        : asynchronous, active-low reset
//   link         : serial link (CS, SCK in; SDO out), slave modport
//   sample       : value to serve
//   sample_valid : one-cycle load strobe for sample
//   busy         : synchronized CS is low (frame in progress)
//   frame_done   : one-cycle pulse, frame completed
//   frame_abort  : one-cycle pulse, frame ended before the data was out
//   frame_count  : completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module als_adc_responder #(
    parameter int DATA_W    = 8,
    parameter int LEAD_Z    = 3,
    parameter int FRAME_LEN = 16
) (
    input  logic               clk_25M,
    input  logic               reset,
    als_adc_responder_if.slave link,
    input  logic [DATA_W-1:0]  sample,
    input  logic               sample_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_abort,
    output logic [7:0]         frame_count
);

    localparam int IDX_W = $clog2(FRAME_LEN + 1);
    localparam int TAIL  = FRAME_LEN - LEAD_Z - DATA_W;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state;
    state_t next_state;

    logic [2:0] cs_sync;
    logic [2:0] sck_sync;
    logic       cs_fall;
    logic       cs_rise;
    logic       sck_fall;

    logic [DATA_W-1:0]    shadow;
    logic [DATA_W-1:0]    pending;
    logic                 pend;
    logic [FRAME_LEN-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 sdo;

    logic                 load_frame;
    logic                 shift_en;
    logic                 end_frame;
    logic [FRAME_LEN-1:0] frame_word;

    // Two synchronizing flops plus a history flop per pin; reset to the idle
    // levels (CS high, SCK high) so no spurious CS edge follows reset.
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            cs_sync  <= 3'b111;
            sck_sync <= 3'b111;
        end else begin
            cs_sync  <= {cs_sync[1:0], link.CS};
            sck_sync <= {sck_sync[1:0], link.SCK};
        end
    end

    assign cs_fall  =  cs_sync[2] & ~cs_sync[1];
    assign cs_rise  = ~cs_sync[2] &  cs_sync[1];
    assign sck_fall =  sck_sync[2] & ~sck_sync[1];

    assign frame_word = {{(FRAME_LEN - DATA_W){1'b0}}, shadow} << TAIL;

    // State register.
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a frame is bracketed by the CS edges.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cs_fall) next_state = SHIFT;
            SHIFT:   if (cs_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control decode. A CS rise beats an SCK fall landing in the same cycle.
    always_comb begin
        load_frame = 1'b0;
        shift_en   = 1'b0;
        end_frame  = 1'b0;
        case (state)
            IDLE:  load_frame = cs_fall;
            SHIFT: begin
                end_frame = cs_rise;
                shift_en  = sck_fall & ~cs_rise;
            end
            default: ;
        endcase
    end

    // Datapath. Samples arriving while a frame is starting or running are
    // parked in pending so the frame in flight is never disturbed; the last
    // parked value becomes the shadow when the frame ends.
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            shadow      <= '0;
            pending     <= '0;
            pend        <= 1'b0;
            shift       <= '0;
            bit_idx     <= '0;
            sdo         <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_count <= '0;
        end else begin
            busy        <= ~cs_sync[1];
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;

            if (end_frame) begin
                sdo <= 1'b0;
                if (bit_idx >= IDX_W'(LEAD_Z + DATA_W)) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    frame_abort <= 1'b1;
                end
                if (sample_valid) begin
                    shadow <= sample;
                end else if (pend) begin
                    shadow <= pending;
                end
                pend <= 1'b0;
            end else if (load_frame) begin
                shift   <= frame_word;
                sdo     <= frame_word[FRAME_LEN-1];
                bit_idx <= '0;
                if (sample_valid) begin
                    pending <= sample;
                    pend    <= 1'b1;
                end
            end else begin
                if (shift_en) begin
                    shift <= shift << 1;
                    sdo   <= shift[FRAME_LEN-2];
                    if (bit_idx != IDX_W'(FRAME_LEN)) begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                if (sample_valid) begin
                    if (state == SHIFT) begin
                        pending <= sample;
                        pend    <= 1'b1;
                    end else begin
                        shadow <= sample;
                    end
                end
            end
        end
    end

    assign link.SDO = sdo;

endmodule
